mem_responder: RTL and testbench

- Target side of the processor memory bus (`m_addr`/`m_data`/`m_rw`/`m_q`): a single-port 2^ADDR_W x DATA_W word store that answers processor reads and writes.
- Adds a valid/ready program-load port, so host/test logic can fill instruction memory before `exec`.
- Includes a post-reset clear sweep that zeroes every word.
- Sits between the processor core and the top level; the only memory in the design.

---
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word store answering the processor memory bus, with a valid/ready program-load port and a post-reset clear sweep.
// Optional MEM_RESPONDER_MMIO_EN maps the top word address onto io_out (write) / io_in (read).
module mem_responder #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_data,
   input  logic              m_rw,
   output logic [DATA_W-1:0] m_q,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              busy,
   output logic [ADDR_W:0]   ld_count
`ifdef MEM_RESPONDER_MMIO_EN
   ,
   output logic [DATA_W-1:0] io_out,
   input  logic [DATA_W-1:0] io_in
`endif
);

   typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_MAX   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   state_t             r_state;
   state_t             w_next;
   logic [ADDR_W-1:0]  r_clr_addr;
   logic [DATA_W-1:0]  r_mem [0:(2**ADDR_W)-1];
   logic [DATA_W-1:0]  r_q;
   logic [ADDR_W:0]    r_ld_count;

   logic               w_wr;
   logic               w_busy;
   logic               w_ld_ready;
   logic               w_ld_fire;
   logic               w_clr_last;
   logic               w_io_hit;
   logic               w_mem_we;
   logic [ADDR_W-1:0]  w_mem_addr;
   logic [DATA_W-1:0]  w_mem_data;
   logic [DATA_W-1:0]  w_rd_data;

   // An unknown m_rw falls through to the read path, so it never writes.
   always_comb begin
      w_wr = 1'b0;
      if (m_rw) w_wr = 1'b1;
   end

   assign w_clr_last = (r_clr_addr == ADDR_LAST);
   assign w_ld_fire  = ld_valid & w_ld_ready;

`ifdef MEM_RESPONDER_MMIO_EN
   logic [DATA_W-1:0] r_io_out;

   assign w_io_hit  = (m_addr == ADDR_LAST);
   assign w_rd_data = w_io_hit ? io_in : r_mem[m_addr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                      r_io_out <= '0;
      else if (r_state == S_CLEAR)    r_io_out <= '0;
      else if (w_wr && w_io_hit)      r_io_out <= m_data;
   end

   assign io_out = r_io_out;
`else
   assign w_io_hit  = 1'b0;
   assign w_rd_data = r_mem[m_addr];
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_CLEAR;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (r_state == S_CLEAR && w_clr_last) w_next = S_READY;
   end

   always_comb begin
      w_busy     = (r_state == S_CLEAR);
      w_ld_ready = (r_state == S_READY) & ~w_wr;
   end

   // Sweep owns the port while clearing; a processor write outranks a load.
   always_comb begin
      w_mem_we   = 1'b0;
      w_mem_addr = r_clr_addr;
      w_mem_data = '0;
      if (r_state == S_CLEAR) begin
         w_mem_we = 1'b1;
      end else if (w_wr) begin
         w_mem_we   = ~w_io_hit;
         w_mem_addr = m_addr;
         w_mem_data = m_data;
      end else if (w_ld_fire) begin
         w_mem_we   = 1'b1;
         w_mem_addr = ld_addr;
         w_mem_data = ld_data;
      end
   end

   always_ff @(posedge clock) begin
      if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                   r_clr_addr <= '0;
      else if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + ADDR_ONE;
   end

   // Read samples the array before a same-edge load lands, returning the pre-load word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (r_state == S_READY) begin
         if (w_wr) r_q <= m_data;
         else      r_q <= w_rd_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                 r_ld_count <= '0;
      else if (w_ld_fire && r_ld_count != CNT_MAX) r_ld_count <= r_ld_count + CNT_ONE;
   end

   assign m_q      = r_q;
   assign busy     = w_busy;
   assign ld_ready = w_ld_ready;
   assign ld_count = r_ld_count;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table plus hand sequences for clear, reset-during-load and saturation.
// Also covers the MEM_RESPONDER_MMIO_EN build when that macro is defined.
module tb_mem_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] m_addr;
   logic [15:0] m_data;
   logic        m_rw;
   logic [15:0] m_q;
   logic        ld_valid;
   logic        ld_ready;
   logic [11:0] ld_addr;
   logic [15:0] ld_data;
   logic        busy;
   logic [12:0] ld_count;
`ifdef MEM_RESPONDER_MMIO_EN
   logic [15:0] io_out;
   logic [15:0] io_in;
`endif

   mem_responder #(.ADDR_W(12), .DATA_W(16)) dut (
      .clock    (clock),
      .reset    (reset),
      .m_addr   (m_addr),
      .m_data   (m_data),
      .m_rw     (m_rw),
      .m_q      (m_q),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .busy     (busy),
      .ld_count (ld_count)
`ifdef MEM_RESPONDER_MMIO_EN
      ,
      .io_out   (io_out),
      .io_in    (io_in)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rw;
      logic [11:0] addr;
      logic [15:0] wdata;
      logic        ldv;
      logic [11:0] lda;
      logic [15:0] ldd;
      logic        exp_rdy;
      logic [15:0] exp_q;
      logic [12:0] exp_cnt;
   } vec_t;

   vec_t        vecs [18];
   logic [15:0] sb [$];
   int          total = 0;
   int          bad   = 0;

   function automatic vec_t mk(input logic rw, input logic [11:0] addr, input logic [15:0] wdata,
                               input logic ldv, input logic [11:0] lda, input logic [15:0] ldd,
                               input logic exp_rdy, input logic [15:0] exp_q, input logic [12:0] exp_cnt);
      vec_t v;
      v.rw = rw; v.addr = addr; v.wdata = wdata;
      v.ldv = ldv; v.lda = lda; v.ldd = ldd;
      v.exp_rdy = exp_rdy; v.exp_q = exp_q; v.exp_cnt = exp_cnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      m_rw = 1'b0; m_addr = '0; m_data = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
   endtask

   // Expected m_q is queued at drive time and retired after the edge that produces it.
   task automatic drive(input string tag, input vec_t v);
      m_rw = v.rw; m_addr = v.addr; m_data = v.wdata;
      ld_valid = v.ldv; ld_addr = v.lda; ld_data = v.ldd;
      sb.push_back(v.exp_q);
      #1;
      check({tag, ".ld_ready"}, 32'(ld_ready), 32'(v.exp_rdy));
      @(posedge clock); #1;
      if (sb.size() == 0) check({tag, ".sb_empty"}, 32'd1, 32'd0);
      else check({tag, ".m_q"}, 32'(m_q), 32'(sb.pop_front()));
      check({tag, ".ld_count"}, 32'(ld_count), 32'(v.exp_cnt));
   endtask

   task automatic wait_clear(output int n, output int qnz);
      n = 0; qnz = 0;
      while (busy === 1'b1 && n < 5000) begin
         @(posedge clock); #1;
         n++;
         if (m_q !== 16'h0000) qnz++;
      end
   endtask

   int n_clr;
   int q_nz;

   initial begin
      vecs[0]  = mk(0, 12'h000, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h0000, 13'd0);
      vecs[1]  = mk(0, 12'h7FF, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h0000, 13'd0);
      vecs[2]  = mk(0, 12'hFFF, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h0000, 13'd0);
      vecs[3]  = mk(0, 12'h000, 16'h0000, 1, 12'h000, 16'hB801, 1, 16'h0000, 13'd1);
      vecs[4]  = mk(0, 12'h000, 16'h0000, 1, 12'h001, 16'hC0F5, 1, 16'hB801, 13'd2);
      vecs[5]  = mk(0, 12'h001, 16'h0000, 1, 12'h002, 16'h4A10, 1, 16'hC0F5, 13'd3);
      vecs[6]  = mk(0, 12'h002, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h4A10, 13'd3);
      vecs[7]  = mk(1, 12'h123, 16'hBEEF, 1, 12'h200, 16'h9C3D, 0, 16'hBEEF, 13'd3);
      vecs[8]  = mk(0, 12'h123, 16'h0000, 1, 12'h200, 16'h9C3D, 1, 16'hBEEF, 13'd4);
      vecs[9]  = mk(0, 12'h200, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h9C3D, 13'd4);
      vecs[10] = mk(0, 12'h010, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h0000, 13'd4);
      vecs[11] = mk(1, 12'h010, 16'h5A5A, 0, 12'h000, 16'h0000, 0, 16'h5A5A, 13'd4);
      vecs[12] = mk(0, 12'h010, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h5A5A, 13'd4);
      vecs[13] = mk(0, 12'h020, 16'h0000, 1, 12'h020, 16'h7777, 1, 16'h0000, 13'd5);
      vecs[14] = mk(0, 12'h020, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h7777, 13'd5);
      vecs[15] = mk(1, 12'h7FF, 16'h1111, 0, 12'h000, 16'h0000, 0, 16'h1111, 13'd5);
      vecs[16] = mk(0, 12'h7FF, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'h1111, 13'd5);
      vecs[17] = mk(0, 12'h000, 16'h0000, 0, 12'h000, 16'h0000, 1, 16'hB801, 13'd5);

      reset = 1'b1;
      idle();
`ifdef MEM_RESPONDER_MMIO_EN
      io_in = 16'h0000;
`endif
      repeat (3) @(posedge clock);
      #1;
      check("rst.m_q", 32'(m_q), 32'h0);
      check("rst.busy", 32'(busy), 32'h1);
      check("rst.ld_ready", 32'(ld_ready), 32'h0);
      check("rst.ld_count", 32'(ld_count), 32'h0);
`ifdef MEM_RESPONDER_MMIO_EN
      check("rst.io_out", 32'(io_out), 32'h0);
`endif
      reset = 1'b0;
      wait_clear(n_clr, q_nz);
      check("clr1.busy_cycles", 32'(n_clr), 32'd4096);
      check("clr1.m_q_nonzero", 32'(q_nz), 32'd0);
      check("clr1.busy_low", 32'(busy), 32'h0);

      for (int i = 0; i < 18; i++) drive($sformatf("vec%0d", i), vecs[i]);
      idle();

      for (int i = 0; i < 4100; i++) begin
         ld_valid = 1'b1; ld_addr = 12'(i); ld_data = 16'hA000 | 16'(i);
         @(posedge clock); #1;
      end
      idle();
      check("sat.ld_count", 32'(ld_count), 32'd4096);

      for (int i = 0; i < 100; i++) begin
         ld_valid = 1'b1; ld_addr = 12'(i); ld_data = 16'hA000 | 16'(i);
         @(posedge clock); #1;
      end
      #2 reset = 1'b1;
      #1;
      check("rst2.ld_count", 32'(ld_count), 32'h0);
      check("rst2.busy", 32'(busy), 32'h1);
      check("rst2.ld_ready", 32'(ld_ready), 32'h0);
      check("rst2.m_q", 32'(m_q), 32'h0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      m_rw = 1'b1; m_addr = 12'h050; m_data = 16'hFFFF;
      ld_valid = 1'b1; ld_addr = 12'h060; ld_data = 16'h1234;
      wait_clear(n_clr, q_nz);
      idle();
      check("clr2.busy_cycles", 32'(n_clr), 32'd4096);
      check("clr2.m_q_nonzero", 32'(q_nz), 32'd0);
      check("clr2.ld_count", 32'(ld_count), 32'h0);
      drive("clr2.rd001", mk(0, 12'h001, 16'h0, 0, 12'h0, 16'h0, 1, 16'h0000, 13'd0));
      drive("clr2.rd050", mk(0, 12'h050, 16'h0, 0, 12'h0, 16'h0, 1, 16'h0000, 13'd0));
      drive("clr2.rd060", mk(0, 12'h060, 16'h0, 0, 12'h0, 16'h0, 1, 16'h0000, 13'd0));

`ifdef MEM_RESPONDER_MMIO_EN
      check("mmio.io_out_clr", 32'(io_out), 32'h0);
      m_rw = 1'b1; m_addr = 12'hFFF; m_data = 16'h00C3;
      @(posedge clock); #1;
      idle();
      check("mmio.io_out", 32'(io_out), 32'h00C3);
      io_in = 16'h1234;
      drive("mmio.rd_io", mk(0, 12'hFFF, 16'h0, 0, 12'h0, 16'h0, 1, 16'h1234, 13'd0));
      drive("mmio.ld_fff", mk(0, 12'h000, 16'h0, 1, 12'hFFF, 16'h5555, 1, 16'h0000, 13'd1));
      check("mmio.io_out_kept", 32'(io_out), 32'h00C3);
      drive("mmio.rd_io2", mk(0, 12'hFFF, 16'h0, 0, 12'h0, 16'h0, 1, 16'h1234, 13'd1));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
